// File: rtl/cmt_pkg.sv
// Shared types for the compare/match timer: FSM state encoding and its width.
package cmt_pkg;

  localparam int CMT_STATE_W = 2;

  typedef enum logic [CMT_STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } cmt_state_e;

endpackage

// File: rtl/cmt_shadow_regs.sv
// Double-buffered period/compare registers: software writes land in the shadow
// pair, and the FSM decides when the shadow pair becomes the active one.
module cmt_shadow_regs
  import cmt_pkg::*;
#(
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] period_i,
  input  logic [DATA_WIDTH-1:0] compare_i,
  input  logic                  xfer_en_i,
  output logic                  load_ready_o,
  output logic [DATA_WIDTH-1:0] period_act_o,
  output logic [DATA_WIDTH-1:0] compare_act_o
);

  logic                  pending;
  logic [DATA_WIDTH-1:0] period_sh;
  logic [DATA_WIDTH-1:0] compare_sh;
  logic                  capture;
  logic                  xfer;

  // Ready is the inverse of pending, so a capture can never land on a transfer cycle.
  assign load_ready_o = ~pending;
  assign capture      = load_valid_i & ~pending;
  assign xfer         = pending & xfer_en_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending       <= 1'b0;
      period_sh     <= '0;
      compare_sh    <= '0;
      period_act_o  <= '0;
      compare_act_o <= '0;
    end else if (capture) begin
      period_sh  <= period_i;
      compare_sh <= compare_i;
      pending    <= 1'b1;
    end else if (xfer) begin
      period_act_o  <= period_sh;
      compare_act_o <= compare_sh;
      pending       <= 1'b0;
    end
  end

endmodule

// File: rtl/compare_match_timer.sv
// Programmable up-counter with match/wrap pulses and a PWM level; period and
// compare are reloaded through a shadow stage so a running cycle never glitches.
module compare_match_timer
  import cmt_pkg::*;
#(
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  pause_i,
  input  logic                  stop_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [DATA_WIDTH-1:0] period_i,
  input  logic [DATA_WIDTH-1:0] compare_i,
  output logic [DATA_WIDTH-1:0] count_o,
  output logic                  match_o,
  output logic                  wrap_o,
  output logic                  pwm_o,
  output logic                  running_o
);

  cmt_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] count_nxt;
  logic [DATA_WIDTH-1:0] period_act;
  logic [DATA_WIDTH-1:0] compare_act;
  logic                  is_run;
  logic                  is_pause;
  logic                  wrap_hit;
  logic                  cmp_hit;
  logic                  xfer_en;

  assign is_run   = (state == RUN);
  assign is_pause = (state == PAUSE);
  assign wrap_hit = (count_o == period_act);
  assign cmp_hit  = (count_o == compare_act);

  // Outside RUN the active regs can refresh at once; in RUN only at the wrap.
  assign xfer_en = ~is_run | wrap_hit;

  cmt_shadow_regs #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shadow (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_valid_i  (load_valid_i),
    .period_i      (period_i),
    .compare_i     (compare_i),
    .xfer_en_i     (xfer_en),
    .load_ready_o  (load_ready_o),
    .period_act_o  (period_act),
    .compare_act_o (compare_act)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count_o <= '0;
    end else begin
      state   <= state_nxt;
      count_o <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count_o;
    unique case (state)
      IDLE: begin
        count_nxt = '0;
        if (!pause_i && start_i) state_nxt = RUN;
      end
      RUN: begin
        // A wrap still executes on the cycle pause is requested.
        if (wrap_hit)      count_nxt = '0;
        else if (!pause_i) count_nxt = count_o + 1'b1;
        if (pause_i) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (!pause_i && start_i) state_nxt = RUN;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
    if (stop_i) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end
  end

  assign match_o   = is_run & cmp_hit;
  assign wrap_o    = is_run & wrap_hit;
  assign pwm_o     = (is_run | is_pause) & (count_o < compare_act);
  assign running_o = is_run;

endmodule

// File: tb/tb_compare_match_timer.sv
// Bench for compare_match_timer: a directed vector table, corner sequences and
// random traffic, all checked against a cycle-level reference model.
module tb_compare_match_timer;

  localparam int DW  = 13;
  localparam int MOD = 1 << DW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0, pause_i = 1'b0, stop_i = 1'b0, load_valid_i = 1'b0;
  logic          load_ready_o;
  logic [DW-1:0] period_i = '0, compare_i = '0;
  logic [DW-1:0] count_o;
  logic          match_o, wrap_o, pwm_o, running_o;

  compare_match_timer #(.DATA_WIDTH(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pause_i      (pause_i),
    .stop_i       (stop_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .period_i     (period_i),
    .compare_i    (compare_i),
    .count_o      (count_o),
    .match_o      (match_o),
    .wrap_o       (wrap_o),
    .pwm_o        (pwm_o),
    .running_o    (running_o)
  );

  always #5 clk_i = ~clk_i;

  int errs = 0;
  int checks = 0;

  // reference model: mode 0=idle 1=run 2=pause
  int m_mode, m_cnt, m_pact, m_cact, m_psh, m_csh;
  bit m_pend;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pact = 0; m_cact = 0; m_psh = 0; m_csh = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit sp, input bit lv,
                            input int p, input int c);
    int  nmode, ncnt;
    bit  at_end;
    at_end = (m_mode == 1) && (m_cnt == m_pact);
    if (sp)      nmode = 0;
    else if (pa) nmode = (m_mode == 1) ? 2 : m_mode;
    else if (st) nmode = 1;
    else         nmode = m_mode;
    if (sp || m_mode == 0) ncnt = 0;
    else if (m_mode == 1)  ncnt = at_end ? 0 : (pa ? m_cnt : (m_cnt + 1) % MOD);
    else                   ncnt = m_cnt;
    if (m_pend && (m_mode != 1 || at_end)) begin
      m_pact = m_psh; m_cact = m_csh; m_pend = 0;
    end else if (lv && !m_pend) begin
      m_psh = p; m_csh = c; m_pend = 1;
    end
    m_mode = nmode;
    m_cnt  = ncnt;
  endtask

  task automatic check_model();
    chk("count", int'(count_o), m_cnt);
    chk("match", int'(match_o), int'(m_mode == 1 && m_cnt == m_cact));
    chk("wrap", int'(wrap_o), int'(m_mode == 1 && m_cnt == m_pact));
    chk("pwm", int'(pwm_o), int'(m_mode != 0 && m_cnt < m_cact));
    chk("running", int'(running_o), int'(m_mode == 1));
    chk("load_ready", int'(load_ready_o), int'(!m_pend));
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model and DUT, check.
  task automatic step(input bit st, input bit pa, input bit sp, input bit lv,
                      input int p, input int c);
    start_i = st; pause_i = pa; stop_i = sp; load_valid_i = lv;
    period_i = DW'(p); compare_i = DW'(c);
    model_step(st, pa, sp, lv, p, c);
    @(posedge clk_i);
    @(negedge clk_i);
    check_model();
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // stop, load the pair while idle, let it transfer, then start at count 0
  task automatic restart_with(input int p, input int c);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, p, c);
    idle_cycle();
    step(1, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit st, pa, sp, lv;
    int p, c;
    int e_cnt;
    bit e_m, e_w, e_pwm, e_run, e_rdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // load P=4,C=2 in idle, run one period, then reload P=2,C=1 mid-run
    tbl[0]  = '{0,0,0,1,4,2, 0,0,0,0,0,0};
    tbl[1]  = '{0,0,0,0,0,0, 0,0,0,0,0,1};
    tbl[2]  = '{1,0,0,0,0,0, 0,0,0,1,1,1};
    tbl[3]  = '{0,0,0,0,0,0, 1,0,0,1,1,1};
    tbl[4]  = '{0,0,0,0,0,0, 2,1,0,0,1,1};
    tbl[5]  = '{0,0,0,0,0,0, 3,0,0,0,1,1};
    tbl[6]  = '{0,0,0,0,0,0, 4,0,1,0,1,1};
    tbl[7]  = '{0,0,0,0,0,0, 0,0,0,1,1,1};
    tbl[8]  = '{0,0,0,0,0,0, 1,0,0,1,1,1};
    tbl[9]  = '{0,0,0,1,2,1, 2,1,0,0,1,0};
    tbl[10] = '{0,0,0,1,7,7, 3,0,0,0,1,0};
    tbl[11] = '{0,0,0,0,0,0, 4,0,1,0,1,0};
    tbl[12] = '{0,0,0,0,0,0, 0,0,0,1,1,1};
    tbl[13] = '{0,0,0,0,0,0, 1,1,0,0,1,1};
    tbl[14] = '{0,0,0,0,0,0, 2,0,1,0,1,1};
    tbl[15] = '{0,0,0,0,0,0, 0,0,0,1,1,1};

    model_reset();
    repeat (2) @(negedge clk_i);
    check_model();
    rst_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].pa, tbl[i].sp, tbl[i].lv, tbl[i].p, tbl[i].c);
      chk($sformatf("vec%0d count", i), int'(count_o), tbl[i].e_cnt);
      chk($sformatf("vec%0d match", i), int'(match_o), int'(tbl[i].e_m));
      chk($sformatf("vec%0d wrap", i), int'(wrap_o), int'(tbl[i].e_w));
      chk($sformatf("vec%0d pwm", i), int'(pwm_o), int'(tbl[i].e_pwm));
      chk($sformatf("vec%0d running", i), int'(running_o), int'(tbl[i].e_run));
      chk($sformatf("vec%0d ready", i), int'(load_ready_o), int'(tbl[i].e_rdy));
    end

    // pause at count 3 for 5 cycles, then resume 3,4,0
    restart_with(4, 2);
    repeat (3) idle_cycle();
    chk("pre-pause count", int'(count_o), 3);
    step(0, 1, 0, 0, 0, 0);
    repeat (4) begin
      chk("paused count", int'(count_o), 3);
      chk("paused pwm", int'(pwm_o), 0);
      chk("paused pulses", int'(match_o | wrap_o), 0);
      idle_cycle();
    end
    step(1, 0, 0, 0, 0, 0);
    chk("resume count", int'(count_o), 3);
    idle_cycle();
    chk("resume wrap", int'(wrap_o), 1);
    idle_cycle();
    chk("resume zero", int'(count_o), 0);

    // P=0: wrap every run cycle; with C=0 match too, pwm off
    restart_with(0, 0);
    repeat (3) begin
      chk("p0 wrap", int'(wrap_o), 1);
      chk("p0 match", int'(match_o), 1);
      chk("p0 pwm", int'(pwm_o), 0);
      idle_cycle();
    end

    // C=7 above P=4: pwm always high, never a match
    restart_with(4, 7);
    repeat (7) begin
      chk("c7 pwm", int'(pwm_o), 1);
      chk("c7 match", int'(match_o), 0);
      idle_cycle();
    end

    // start+stop together from pause
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("startstop count", int'(count_o), 0);
    chk("startstop running", int'(running_o), 0);

    // full-range period wraps cleanly
    restart_with(MOD - 1, 100);
    repeat (MOD - 1) idle_cycle();
    chk("pmax count", int'(count_o), MOD - 1);
    chk("pmax wrap", int'(wrap_o), 1);
    idle_cycle();
    chk("pmax zero", int'(count_o), 0);

    // async reset while running at count 5
    restart_with(10, 3);
    repeat (5) idle_cycle();
    chk("pre-reset count", int'(count_o), 5);
    #2 rst_i = 1'b1;
    #1;
    chk("rst count", int'(count_o), 0);
    chk("rst running", int'(running_o), 0);
    chk("rst ready", int'(load_ready_o), 1);
    chk("rst outs", int'(match_o | wrap_o | pwm_o), 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_cycle();

    // random traffic with small periods so every event is frequent
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 10, (r >= 10 && r < 14), r == 14 || r == 15, $urandom_range(0, 3) == 0,
           $urandom_range(0, 12), $urandom_range(0, 14));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
